// File: rtl/split_n.sv
// -----------------------------------------------------------------------------
// split_n
// Registered N-way address splitter for the memory-subsystem model.
//
// One upstream request is decoded by ascending base address to exactly one of
// NUM_PORTS downstream memories. The address is rebased to that port, the port
// is strobed for a single cycle, and the splitter then waits for the port's
// completion before returning read data upstream. An optional timeout aborts a
// port that never completes.
//
// Ports
//   clk     in   1                      clock, rising edge
//   rst     in   1                      asynchronous reset, active-low
//   addr    in   ADDR_WIDTH             request address
//   din     in   WORD_WIDTH             write data
//   dout    out  WORD_WIDTH             read data, valid while ready=1 after a read
//   re      in   1                      read request
//   we      in   1                      write request (wins over re)
//   ready   out  1                      1 = idle, request may be issued
//   err     out  1                      last request timed out
//   maddr   out  NUM_PORTS*ADDR_WIDTH   per-port rebased address, slice i = port i
//   mout    out  NUM_PORTS*WORD_WIDTH   per-port write data
//   min     in   NUM_PORTS*WORD_WIDTH   per-port read data
//   mre     out  NUM_PORTS              per-port read strobe
//   mwe     out  NUM_PORTS              per-port write strobe
//   mready  in   NUM_PORTS              per-port idle/complete
//
// Parameters
//   BASES packs the bases of ports 1..NUM_PORTS-1; slice i-1 holds the base of
//   port i. Port 0 always starts at address 0, so every address maps somewhere.
//   TIMEOUT = 0 disables the abort path; otherwise it is the number of WAIT
//   cycles tolerated before the request is abandoned.
// -----------------------------------------------------------------------------
module split_n #(
  parameter int ADDR_WIDTH = 64,
  parameter int WORD_WIDTH = 64,
  parameter int NUM_PORTS  = 4,
  parameter logic [(NUM_PORTS-1)*ADDR_WIDTH-1:0] BASES = {64'h1000, 64'h200, 64'h100},
  parameter int TIMEOUT    = 0,
  parameter int TO_WIDTH   = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [WORD_WIDTH-1:0]           din,
  output logic [WORD_WIDTH-1:0]           dout,
  input  logic                            re,
  input  logic                            we,
  output logic                            ready,
  output logic                            err,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0] maddr,
  output logic [NUM_PORTS*WORD_WIDTH-1:0] mout,
  input  logic [NUM_PORTS*WORD_WIDTH-1:0] min,
  output logic [NUM_PORTS-1:0]            mre,
  output logic [NUM_PORTS-1:0]            mwe,
  input  logic [NUM_PORTS-1:0]            mready
);

  localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registered state and outputs
  // ---------------------------------------------------------------------------
  state_t                          r_state;
  logic [SEL_W-1:0]                r_sel;
  logic                            r_write;
  logic                            r_ready;
  logic                            r_err;
  logic [WORD_WIDTH-1:0]           r_dout;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] r_maddr;
  logic [NUM_PORTS*WORD_WIDTH-1:0] r_mout;
  logic [NUM_PORTS-1:0]            r_mre;
  logic [NUM_PORTS-1:0]            r_mwe;
  logic [TO_WIDTH-1:0]             r_cnt;

  // ---------------------------------------------------------------------------
  // Address decode: highest port whose base is <= addr. Bases ascend, so the
  // last match in an upward scan is the highest one; port 0 is the fallback.
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0]      w_sel;
  logic [ADDR_WIDTH-1:0] w_base;
  logic [ADDR_WIDTH-1:0] w_offset;
  logic [NUM_PORTS-1:0]  w_onehot;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it
    // unassigned; otherwise a latch is inferred.
    w_sel  = '0;
    w_base = '0;
    for (int i = 1; i < NUM_PORTS; i++) begin
      if (addr >= BASES[(i-1)*ADDR_WIDTH +: ADDR_WIDTH]) begin
        w_sel  = SEL_W'(i);
        w_base = BASES[(i-1)*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Rebase wraps modulo 2**ADDR_WIDTH; with ascending bases it never underflows.
  assign w_offset = addr - w_base;
  assign w_onehot = NUM_PORTS'(1) << w_sel;

  // ---------------------------------------------------------------------------
  // Selected port's return path (read data and completion flag)
  // ---------------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] w_min_sel;
  logic                  w_mready_sel;

  always_comb begin
    w_min_sel    = '0;
    w_mready_sel = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (r_sel == SEL_W'(p)) begin
        w_min_sel    = min[p*WORD_WIDTH +: WORD_WIDTH];
        w_mready_sel = mready[p];
      end
    end
  end

  // The counter holds the number of WAIT cycles already completed without
  // mready; the edge ending cycle TIMEOUT is the abort edge.
  logic w_timeout_hit;
  assign w_timeout_hit = (TIMEOUT > 0) && (r_cnt == TO_WIDTH'(TIMEOUT - 1));

  // ---------------------------------------------------------------------------
  // Control FSM: IDLE -> ISSUE -> WAIT -> IDLE, all outputs registered.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_write <= 1'b0;
      r_ready <= 1'b1;
      r_err   <= 1'b0;
      r_dout  <= '0;
      r_maddr <= '0;
      r_mout  <= '0;
      r_mre   <= '0;
      r_mwe   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (re | we) begin
            r_sel   <= w_sel;
            r_write <= we;
            r_err   <= 1'b0;
            r_ready <= 1'b0;
            // Only the selected slice moves; other ports keep what they had.
            for (int p = 0; p < NUM_PORTS; p++) begin
              if (w_sel == SEL_W'(p)) begin
                r_maddr[p*ADDR_WIDTH +: ADDR_WIDTH] <= w_offset;
                r_mout[p*WORD_WIDTH +: WORD_WIDTH]  <= din;
              end
            end
            if (we) begin
              r_mwe <= w_onehot;
            end else begin
              r_mre <= w_onehot;
            end
            r_state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // Strobe lasts exactly this one cycle; mready is not looked at yet
          // because the port only reacts to the strobe in the next cycle.
          r_mre   <= '0;
          r_mwe   <= '0;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (w_mready_sel) begin
            // Completion is checked first so it beats a coincident expiry.
            if (!r_write) begin
              r_dout <= w_min_sel;
            end
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_timeout_hit) begin
            r_err <= 1'b1;
            if (!r_write) begin
              r_dout <= '1;
            end
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          // Unreachable encoding: fall back to a clean idle.
          r_mre   <= '0;
          r_mwe   <= '0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output drive
  // ---------------------------------------------------------------------------
  assign ready = r_ready;
  assign err   = r_err;
  assign dout  = r_dout;
  assign maddr = r_maddr;
  assign mout  = r_mout;
  assign mre   = r_mre;
  assign mwe   = r_mwe;

endmodule

// File: tb/tb_split_n.sv
// -----------------------------------------------------------------------------
// tb_split_n
// Self-checking bench for split_n with four ports (bases 0/0x100/0x200/0x1000)
// and an 8-cycle timeout. A transaction-level model tracks the outstanding
// request and its age in cycles; a compare process checks every DUT output
// against it on each falling edge. Directed sequences add literal checks.
// -----------------------------------------------------------------------------
module tb_split_n;

  localparam int AW = 64;
  localparam int WW = 64;
  localparam int NP = 4;
  localparam int TO = 8;
  localparam logic [63:0] BASE [NP] = '{64'h0, 64'h100, 64'h200, 64'h1000};

  logic                 clk;
  logic                 rst;
  logic [AW-1:0]        addr;
  logic [WW-1:0]        din;
  logic [WW-1:0]        dout;
  logic                 re;
  logic                 we;
  logic                 ready;
  logic                 err;
  logic [NP*AW-1:0]     maddr;
  logic [NP*WW-1:0]     mout;
  logic [NP*WW-1:0]     min_v;
  logic [NP-1:0]        mre;
  logic [NP-1:0]        mwe;
  logic [NP-1:0]        mready;

  int n_tests = 0;
  int n_fail  = 0;

  split_n #(
    .ADDR_WIDTH(AW),
    .WORD_WIDTH(WW),
    .NUM_PORTS (NP),
    .BASES     ({64'h1000, 64'h200, 64'h100}),
    .TIMEOUT   (TO),
    .TO_WIDTH  (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .re    (re),
    .we    (we),
    .ready (ready),
    .err   (err),
    .maddr (maddr),
    .mout  (mout),
    .min   (min_v),
    .mre   (mre),
    .mwe   (mwe),
    .mready(mready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one outstanding request, aged in clock edges since accept.
  // Age 0 is the strobe cycle; mready is looked at from age 2 onward, and the
  // number of WAIT cycles spent so far is age-1.
  // ---------------------------------------------------------------------------
  bit          m_busy  = 1'b0;
  int          m_port  = 0;
  bit          m_write = 1'b0;
  int          m_age   = 0;
  bit          m_err   = 1'b0;
  logic [63:0] m_dout  = '0;
  logic [63:0] m_maddr [NP] = '{default: '0};
  logic [63:0] m_mout  [NP] = '{default: '0};

  function automatic int decode(input logic [63:0] a);
    int p = 0;
    for (int i = 1; i < NP; i++) if (a >= BASE[i]) p = i;
    return p;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_busy = 1'b0; m_err = 1'b0; m_dout = '0; m_age = 0; m_port = 0; m_write = 1'b0;
        for (int p = 0; p < NP; p++) begin
          m_maddr[p] = '0;
          m_mout[p]  = '0;
        end
      end else if (!m_busy) begin
        if (re || we) begin
          m_port          = decode(addr);
          m_maddr[m_port] = addr - BASE[m_port];
          m_mout[m_port]  = din;
          m_write         = we;
          m_err           = 1'b0;
          m_busy          = 1'b1;
          m_age           = 0;
        end
      end else begin
        m_age++;
        if (m_age >= 2) begin
          if (mready[m_port]) begin
            if (!m_write) m_dout = min_v[m_port*WW +: WW];
            m_busy = 1'b0;
          end else if (m_age - 1 == TO) begin
            m_err = 1'b1;
            if (!m_write) m_dout = '1;
            m_busy = 1'b0;
          end
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      begin
        logic [NP-1:0] e_mre;
        logic [NP-1:0] e_mwe;
        e_mre = '0;
        e_mwe = '0;
        if (m_busy && m_age == 0) begin
          if (m_write) e_mwe = NP'(1) << m_port;
          else         e_mre = NP'(1) << m_port;
        end
        check("model ready", 64'(ready), 64'(!m_busy));
        check("model err",   64'(err),   64'(m_err));
        check("model dout",  dout,       m_dout);
        check("model mre",   64'(mre),   64'(e_mre));
        check("model mwe",   64'(mwe),   64'(e_mwe));
        for (int p = 0; p < NP; p++) begin
          check($sformatf("model maddr%0d", p), maddr[p*AW +: AW], m_maddr[p]);
          check($sformatf("model mout%0d", p),  mout[p*WW +: WW],  m_mout[p]);
        end
      end
    end
  end

  // Count read strobe cycles on port 0.
  int n_mre0 = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (mre[0]) n_mre0++;
    end
  end

  // Hard stop if something hangs beyond any sane run length.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge; returns 1 time unit after the accept edge.
  task automatic issue(input logic [63:0] a, input logic r, input logic w, input logic [63:0] d);
    cyc();
    addr = a; re = r; we = w; din = d;
    cyc();
    re = 1'b0; we = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!ready && n < budget) begin
      cyc();
      n++;
    end
    check("wait_ready", 64'(ready), 64'd1);
  endtask

  typedef struct {
    logic [63:0] a;
    int          port;
    logic [63:0] off;
  } vec_t;

  vec_t vecs [5] = '{
    '{64'h1FF,                 1, 64'hFF},
    '{64'h200,                 2, 64'h0},
    '{64'hFFF,                 2, 64'hDFF},
    '{64'h1000,                3, 64'h0},
    '{64'hFFFF_FFFF_FFFF_FFFF, 3, 64'hFFFF_FFFF_FFFF_EFFF}
  };

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst    = 1'b0;
    addr   = '0;
    din    = '0;
    re     = 1'b0;
    we     = 1'b0;
    mready = 4'hF;
    min_v  = {64'hC3C3, 64'hB2B2, 64'hDEAD, 64'hA0A0};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 64'(ready), 64'd1);
    check("reset err",   64'(err),   64'd0);
    check("reset dout",  dout,       64'd0);
    check("reset mre",   64'(mre),   64'd0);
    #3 rst = 1'b1;

    // 1: read 0x150 -> port 1, offset 0x50, data 0xDEAD in the third cycle
    issue(64'h150, 1'b1, 1'b0, 64'h0);
    check("t1 mre strobe", 64'(mre), 64'h2);
    check("t1 maddr1",     maddr[1*AW +: AW], 64'h50);
    check("t1 busy",       64'(ready), 64'd0);
    cyc();
    check("t1 strobe gone", 64'(mre), 64'h0);
    check("t1 still busy",  64'(ready), 64'd0);
    cyc();
    check("t1 ready", 64'(ready), 64'd1);
    check("t1 dout",  dout, 64'hDEAD);

    // 2: decode boundaries
    foreach (vecs[k]) begin
      issue(vecs[k].a, 1'b1, 1'b0, 64'h0);
      check($sformatf("t2 strobe %0d", k), 64'(mre), 64'(NP'(1) << vecs[k].port));
      check($sformatf("t2 offset %0d", k), maddr[vecs[k].port*AW +: AW], vecs[k].off);
      wait_ready(10);
    end
    check("t2 last dout", dout, 64'hC3C3);

    // 3: re and we together -> write wins, dout untouched
    issue(64'h10, 1'b1, 1'b1, 64'h55);
    check("t3 mwe", 64'(mwe), 64'h1);
    check("t3 mre", 64'(mre), 64'h0);
    check("t3 mout0", mout[0 +: WW], 64'h55);
    wait_ready(10);
    check("t3 dout kept", dout, 64'hC3C3);

    // 4a: port 2 never completes -> abort after 8 WAIT cycles
    mready[2] = 1'b0;
    issue(64'h300, 1'b1, 1'b0, 64'h0);
    repeat (8) cyc();
    check("t4 busy at 7 waits", 64'(ready), 64'd0);
    cyc();
    check("t4 ready after abort", 64'(ready), 64'd1);
    check("t4 err",       64'(err), 64'd1);
    check("t4 dout ones", dout, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t4 maddr2",    maddr[2*AW +: AW], 64'h100);

    // 4b: completion on the expiry edge wins; accept clears err
    issue(64'h300, 1'b1, 1'b0, 64'h0);
    check("t4 err cleared", 64'(err), 64'd0);
    repeat (8) cyc();
    mready[2] = 1'b1;
    check("t4b busy", 64'(ready), 64'd0);
    cyc();
    check("t4b ready", 64'(ready), 64'd1);
    check("t4b err",   64'(err), 64'd0);
    check("t4b dout",  dout, 64'hB2B2);

    // 5: request during WAIT is ignored
    begin
      int n0;
      n0 = n_mre0;
      mready[0] = 1'b0;
      issue(64'h40, 1'b1, 1'b0, 64'h0);
      cyc();
      addr = 64'h20; re = 1'b1;
      cyc();
      re = 1'b0;
      repeat (4) cyc();
      mready[0] = 1'b1;
      wait_ready(10);
      repeat (2) cyc();
      check("t5 single strobe", 64'(n_mre0 - n0), 64'd1);
      check("t5 maddr0",        maddr[0 +: AW], 64'h40);
      check("t5 idle",          64'(ready), 64'd1);
      check("t5 dout",          dout, 64'hA0A0);
    end

    // 6: asynchronous reset mid-WAIT, then a normal write
    mready[1] = 1'b0;
    issue(64'h150, 1'b1, 1'b0, 64'h0);
    cyc();
    #2 rst = 1'b0;
    #1;
    check("t6 ready", 64'(ready), 64'd1);
    check("t6 err",   64'(err),   64'd0);
    check("t6 mre",   64'(mre),   64'd0);
    check("t6 mwe",   64'(mwe),   64'd0);
    check("t6 maddr1", maddr[1*AW +: AW], 64'h0);
    check("t6 dout",  dout, 64'h0);
    #2 rst = 1'b1;
    mready = 4'hF;
    issue(64'h210, 1'b0, 1'b1, 64'h77);
    check("t6 write strobe", 64'(mwe), 64'h4);
    check("t6 maddr2",       maddr[2*AW +: AW], 64'h10);
    wait_ready(10);
    check("t6 mout2", mout[2*WW +: WW], 64'h77);
    check("t6 dout after write", dout, 64'h0);

    repeat (2) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
